// File: rtl/deser_pkg.sv
// deser_pkg: widths, byte-lane constants and FSM state type shared by the
// 8->32 deserializer and its idle-timeout helper.
// Pure declarations; no logic, no timing.
package deser_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  // Byte counter is 2 bits wide: 0..3 covers one word exactly.
  localparam int CNT_W = 2;

  // Index of the final byte of a word within the counter range.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

  // Bytes held in the shift register before the final byte arrives.
  localparam int HOLD_W = WORD_W - BYTE_W;

  // IDLE: no partial word held. COLLECT: 1..3 bytes of a word held.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } deser_state_t;

endpackage : deser_pkg

// File: rtl/deser_timeout.sv
// deser_timeout: counts consecutive idle cycles while a partial word is held.
// Latency: expire is combinational on the TIMEOUT-th consecutive idle cycle.
// Backpressure: none; the count clears on any accepted byte or outside COLLECT.
module deser_timeout #(
  parameter int TIMEOUT = 8
) (
  input  logic clk4f,
  input  logic reset_L,
  input  logic collecting,
  input  logic valid_in,
  output logic expire
);

  // Wide enough to hold values 0..TIMEOUT-1.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] idle_cnt;

  // The current idle cycle is the TIMEOUT-th in a row when the count already
  // holds TIMEOUT-1 earlier idle cycles.
  always_comb begin
    expire = collecting && !valid_in && (idle_cnt == LAST);
  end

  // Idle counter: advances on idle cycles inside a partial word, clears on
  // any accepted byte, on expiry, and whenever no partial word is held.
  always_ff @(posedge clk4f) begin
    if (!reset_L) begin
      idle_cnt <= '0;
    end else if (!collecting || valid_in || expire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

endmodule : deser_timeout

// File: rtl/deser_8_32.sv
// deser_8_32: assembles an MSB-first byte stream into 32-bit words.
// Latency: data_out/valid_out register on the edge that accepts the 4th byte.
// Backpressure: none; every byte with valid_in=1 is accepted.
// Optional idle timeout on partial words: define DESER_TIMEOUT_EN.
module deser_8_32
  import deser_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic        clk4f,
  input  logic        reset_L,
  input  logic        valid_in,
  input  logic [7:0]  data_in,
  output logic        valid_out,
  output logic [31:0] data_out,
  output logic        err_drop
);

  // A zero timeout would discard every partial word immediately.
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("deser_8_32: TIMEOUT must be at least 1");
  end

  deser_state_t       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0]  shreg_q, shreg_d;
  logic               word_done;
  logic               drop;
  logic               timeout_hit;

`ifdef DESER_TIMEOUT_EN
  logic err_drop_q;

  deser_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk4f      (clk4f),
    .reset_L    (reset_L),
    .collecting (state_q == COLLECT),
    .valid_in   (valid_in),
    .expire     (timeout_hit)
  );

  // Drop indication: one-cycle pulse after a partial word is abandoned.
  always_ff @(posedge clk4f) begin
    if (!reset_L) begin
      err_drop_q <= 1'b0;
    end else begin
      err_drop_q <= drop;
    end
  end

  assign err_drop = err_drop_q;
`else
  // Partial words are held indefinitely; nothing is ever dropped.
  assign timeout_hit = 1'b0;
  assign err_drop    = 1'b0;
`endif

  // Next-state logic: shift in accepted bytes, close a word on the 4th byte,
  // abandon a partial word on timeout. Idle cycles leave everything as is.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    word_done = 1'b0;
    drop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          shreg_d = {shreg_q[HOLD_W-BYTE_W-1:0], data_in};
          cnt_d   = CNT_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (valid_in) begin
          if (cnt_q == LAST_IDX) begin
            // Final byte goes straight to the output register, so the next
            // word's first byte can land in the shift register next edge.
            word_done = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            shreg_d = {shreg_q[HOLD_W-BYTE_W-1:0], data_in};
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else if (timeout_hit) begin
          drop    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, byte counter and shift register; reset wins over valid_in.
  always_ff @(posedge clk4f) begin
    if (!reset_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Output word register: loads only on word completion so data_out stays
  // stable between pulses; valid_out is a single-cycle strobe.
  always_ff @(posedge clk4f) begin
    if (!reset_L) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= word_done;
      if (word_done) begin
        data_out <= {shreg_q, data_in};
      end
    end
  end

endmodule : deser_8_32

// File: tb/tb_deser_8_32.sv
// tb_deser_8_32: directed-vector bench for deser_8_32.
// Inputs change after the falling edge, outputs are checked at the next one.
// Timeout vectors run only when DESER_TIMEOUT_EN is defined.
module tb_deser_8_32;

  logic        clk4f;
  logic        reset_L;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic        err_drop;

  int checks = 0;
  int errors = 0;

  deser_8_32 #(
    .TIMEOUT (8)
  ) dut (
    .clk4f     (clk4f),
    .reset_L   (reset_L),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .err_drop  (err_drop)
  );

  initial clk4f = 1'b0;
  always #5 clk4f = ~clk4f;

  // Apply one cycle of inputs, let the rising edge take them, return at the
  // following falling edge with outputs settled.
  task automatic cycle(input logic rst_n, input logic v, input logic [7:0] d);
    reset_L  = rst_n;
    valid_in = v;
    data_in  = d;
    @(posedge clk4f);
    @(negedge clk4f);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic vo, input logic [31:0] dout);
    check({tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, vo});
    check({tag, ".data_out"}, data_out, dout);
    check({tag, ".err_drop"}, {31'd0, err_drop}, 32'd0);
  endtask

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    @(negedge clk4f);

    // Reset state, with valid_in high to show it is ignored under reset.
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h5A);
    check_out("reset", 1'b0, 32'h0);

    // All-ones word: single pulse one cycle after the 4th byte.
    cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b1, 1'b1, 8'hFF);
    check_out("ff_b3", 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 8'hFF);
    check_out("ff_word", 1'b1, 32'hFFFFFFFF);
    cycle(1'b1, 1'b0, 8'h00);
    check_out("ff_after", 1'b0, 32'hFFFFFFFF);

    // Back-to-back words: pulses 4 cycles apart, no byte lost at the seam.
    cycle(1'b1, 1'b1, 8'hDD);
    cycle(1'b1, 1'b1, 8'hDD);
    cycle(1'b1, 1'b1, 8'hDD);
    cycle(1'b1, 1'b1, 8'hDD);
    check_out("b2b_w1", 1'b1, 32'hDDDDDDDD);
    cycle(1'b1, 1'b1, 8'h00);
    check_out("b2b_c1", 1'b0, 32'hDDDDDDDD);
    cycle(1'b1, 1'b1, 8'h00);
    check_out("b2b_c2", 1'b0, 32'hDDDDDDDD);
    cycle(1'b1, 1'b1, 8'h00);
    check_out("b2b_c3", 1'b0, 32'hDDDDDDDD);
    cycle(1'b1, 1'b1, 8'h03);
    check_out("b2b_w2", 1'b1, 32'h00000003);

    // Short gap mid-word keeps alignment and raises no drop.
    cycle(1'b1, 1'b1, 8'h00);
    check_out("gap_b1", 1'b0, 32'h00000003);
    cycle(1'b1, 1'b1, 8'h00);
    cycle(1'b1, 1'b0, 8'h77);
    cycle(1'b1, 1'b0, 8'h77);
    cycle(1'b1, 1'b0, 8'h77);
    check_out("gap_idle", 1'b0, 32'h00000003);
    cycle(1'b1, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 8'h03);
    check_out("gap_word", 1'b1, 32'h00000003);

    // Reset mid-word discards the partial word silently.
    cycle(1'b1, 1'b1, 8'hAA);
    cycle(1'b1, 1'b1, 8'hBB);
    cycle(1'b0, 1'b1, 8'hCC);
    check_out("rst_mid", 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 8'h11);
    cycle(1'b1, 1'b1, 8'h22);
    cycle(1'b1, 1'b1, 8'h33);
    check_out("rst_b3", 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 8'h44);
    check_out("rst_word", 1'b1, 32'h11223344);

`ifdef DESER_TIMEOUT_EN
    // Eight idle cycles inside a word: one drop pulse, then clean realignment.
    cycle(1'b1, 1'b1, 8'h12);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'h00);
    check("to_pre.err_drop", {31'd0, err_drop}, 32'd0);
    cycle(1'b1, 1'b0, 8'h00);
    check("to_hit.err_drop", {31'd0, err_drop}, 32'd1);
    check("to_hit.valid_out", {31'd0, valid_out}, 32'd0);
    cycle(1'b1, 1'b0, 8'h00);
    check("to_post.err_drop", {31'd0, err_drop}, 32'd0);
    cycle(1'b1, 1'b1, 8'h01);
    cycle(1'b1, 1'b1, 8'h02);
    cycle(1'b1, 1'b1, 8'h03);
    cycle(1'b1, 1'b1, 8'h04);
    check_out("to_word", 1'b1, 32'h01020304);
`else
    // Long gap: partial word held indefinitely with no drop.
    cycle(1'b1, 1'b1, 8'h12);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 8'h00);
    check_out("hold_idle", 1'b0, 32'h11223344);
    cycle(1'b1, 1'b1, 8'h34);
    cycle(1'b1, 1'b1, 8'h56);
    cycle(1'b1, 1'b1, 8'h78);
    check_out("hold_word", 1'b1, 32'h12345678);
`endif

    cycle(1'b1, 1'b0, 8'h00);
    check_out("final", 1'b0, data_out === 32'hx ? 32'h0 : data_out);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_deser_8_32
